// File: rtl/lane_mem_pkg.sv
// Shared encodings for the lane_memory block: access sizes, fill FSM states
// and the default fill word.
package lane_mem_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // ARM "MOV R0,R0", harmless if executed out of freshly filled RAM.
  localparam logic [31:0] NOP_WORD = 32'hE1A00000;

endpackage

// File: rtl/lane_steer.sv
// Byte-lane steering for a little-endian 32-bit word: store replication and
// byte-enables, plus load alignment and zero/sign extension. Purely combinational.
module lane_steer
  import lane_mem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  // Bring the addressed lane(s) down to bit 0.
  assign shifted = rword >> {off, 3'b000};

  // Store path: replicate data across lanes and pick the byte-enables.
  always_comb begin
    be    = 4'b0000;
    wword = wdata;
    case (size)
      SIZE_BYTE: begin
        be    = 4'b0001 << off;
        wword = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
      end
      SIZE_WORD: begin
        be    = 4'b1111;
        wword = wdata;
      end
      default: begin
        be    = 4'b0000;
        wword = wdata;
      end
    endcase
  end

  // Load path: right-align then extend; word loads ignore sgn.
  always_comb begin
    rdata = rword;
    case (size)
      SIZE_BYTE: rdata = {{24{sgn & shifted[7]}},  shifted[7:0]};
      SIZE_HALF: rdata = {{16{sgn & shifted[15]}}, shifted[15:0]};
      default:   rdata = rword;
    endcase
  end

endmodule

// File: rtl/lane_memory.sv
// Byte-addressable little-endian RAM with one request/response port.
// After reset a fill sequencer writes FILL_WORD to every word, then the port
// opens. Reads are registered (block-RAM friendly); steering of load data is
// done on the registered word using the captured request attributes.
module lane_memory
  import lane_mem_pkg::*;
#(
  parameter int unsigned NUM_OF_BYTES = 1024,
  parameter logic [31:0] FILL_WORD    = NOP_WORD
) (
  input  logic        clk,
  input  logic        mem_reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        init_busy
);

  localparam int unsigned DEPTH = NUM_OF_BYTES / 4;
  localparam int          IW    = $clog2(DEPTH);
  localparam int          PW    = IW + 1;

  state_e          state;
  logic [PW-1:0]   ptr;

  logic [3:0][7:0] mem [DEPTH];
  logic [31:0]     rd_word;

  logic            acc;
  logic            err;
  logic [IW-1:0]   req_idx;

  logic [3:0]      st_be;
  logic [31:0]     st_word;
  logic [31:0]     st_rdata_unused;

  logic [3:0]      wr_be;
  logic [IW-1:0]   wr_idx;
  logic [31:0]     wr_word;

  logic            ld_ok;
  logic [1:0]      ld_off;
  logic [1:0]      ld_size;
  logic            ld_sgn;
  logic [31:0]     ld_data;
  logic [3:0]      ld_be_unused;
  logic [31:0]     ld_wword_unused;

  assign req_ready = (state == ST_READY);
  assign init_busy = (state == ST_INIT);
  assign acc       = req_valid & req_ready;
  assign req_idx   = req_addr[IW+1:2];

  // Any one of these faults the request; range check is on the full 32 bits.
  assign err = (req_size == SIZE_ILLEGAL)
             | (req_addr >= 32'(NUM_OF_BYTES))
             | ((req_size == SIZE_HALF) & req_addr[0])
             | ((req_size == SIZE_WORD) & (req_addr[1:0] != 2'b00));

  // Fill sequencer: one word per cycle from 0 to DEPTH-1, then open the port.
  always_ff @(posedge clk or negedge mem_reset_n) begin
    if (!mem_reset_n) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else if (state == ST_INIT) begin
      ptr <= ptr + PW'(1);
      if (ptr == PW'(DEPTH - 1)) state <= ST_READY;
    end
  end

  // Store-side steering for the request currently on the port.
  lane_steer u_st (
    .off   (req_addr[1:0]),
    .size  (req_size),
    .sgn   (req_signed),
    .wdata (req_wdata),
    .rword (32'h0),
    .be    (st_be),
    .wword (st_word),
    .rdata (st_rdata_unused)
  );

  // Write port mux: the fill owns the array during INIT, errored stores write nothing.
  always_comb begin
    wr_be   = 4'b0000;
    wr_idx  = req_idx;
    wr_word = st_word;
    if (state == ST_INIT) begin
      wr_be   = 4'b1111;
      wr_idx  = ptr[IW-1:0];
      wr_word = FILL_WORD;
    end else if (acc && req_write && !err) begin
      wr_be = st_be;
    end
  end

  // Array with per-byte write enables and a registered read port.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_be[k]) mem[wr_idx][k] <= wr_word[8*k +: 8];
    end
    rd_word <= mem[req_idx];
  end

  // Response registers: one pulse per accepted request, cleared by reset.
  always_ff @(posedge clk or negedge mem_reset_n) begin
    if (!mem_reset_n) begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      ld_ok     <= 1'b0;
      ld_off    <= 2'b00;
      ld_size   <= SIZE_BYTE;
      ld_sgn    <= 1'b0;
    end else begin
      rsp_valid <= acc;
      rsp_error <= acc & err;
      ld_ok     <= acc & ~err & ~req_write;
      ld_off    <= req_addr[1:0];
      ld_size   <= req_size;
      ld_sgn    <= req_signed;
    end
  end

  // Load-side steering on the registered read word.
  lane_steer u_ld (
    .off   (ld_off),
    .size  (ld_size),
    .sgn   (ld_sgn),
    .wdata (32'h0),
    .rword (rd_word),
    .be    (ld_be_unused),
    .wword (ld_wword_unused),
    .rdata (ld_data)
  );

  // Stores, errors and idle cycles all read back as zero.
  assign rsp_rdata = ld_ok ? ld_data : 32'h0;

endmodule

// File: tb/tb_lane_memory.sv
// Scoreboard bench for lane_memory (64 bytes): expectations are queued at
// acceptance and compared as responses appear.
module tb_lane_memory;

  localparam int          NB    = 64;
  localparam int          DEPTH = NB / 4;
  localparam logic [31:0] FILL  = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        mem_reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        init_busy;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] sbq[$];
  logic        acc_prev = 1'b0;
  logic [7:0]  mb [NB];

  lane_memory #(.NUM_OF_BYTES(NB), .FILL_WORD(FILL)) dut (
    .clk(clk), .mem_reset_n(mem_reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  // Which edges accepted a request.
  always @(posedge clk) acc_prev <= req_valid & req_ready & mem_reset_n;

  // Response monitor: pulse timing and in-order scoreboard compare.
  always @(negedge clk) begin
    if (mem_reset_n) begin
      checks++;
      if (rsp_valid !== acc_prev) begin
        errors++;
        $display("FAIL rsp_valid_timing: got %b want %b at %0t", rsp_valid, acc_prev, $time);
      end
      if (rsp_valid === 1'b1) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: no pending request at %0t", $time);
        end else begin
          logic [32:0] e;
          e = sbq.pop_front();
          if ({rsp_error, rsp_rdata} !== e) begin
            errors++;
            $display("FAIL rsp_data: got err=%b data=%h want err=%b data=%h at %0t",
                     rsp_error, rsp_rdata, e[32], e[31:0], $time);
          end
        end
      end
    end
  end

  // Reference model: byte array, filled on every reset.
  task automatic model_fill();
    logic [31:0] fw;
    fw = FILL;
    for (int i = 0; i < NB; i++) mb[i] = fw[8*(i%4) +: 8];
  endtask

  function automatic logic model_bad(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (a >= NB) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [32:0] model_resp(input logic w, input logic [1:0] sz,
                                             input logic sg, input logic [31:0] a);
    logic [31:0] v;
    int n;
    if (model_bad(sz, a)) return {1'b1, 32'h0};
    if (w) return {1'b0, 32'h0};
    n = nbytes(sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mb[a + i]) << (8 * i));
    if (sg && n == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (sg && n == 2 && v[15]) v = v | 32'hFFFF0000;
    return {1'b0, v};
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    if (!model_bad(sz, a))
      for (int i = 0; i < nbytes(sz); i++) mb[a + i] = wd[8*i +: 8];
  endtask

  // Present one request (called at posedge+1), queue its expectation on acceptance.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [32:0] exp);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: req_ready=%b want 1 for addr %h", req_ready, a);
      req_valid = 1'b0;
      return;
    end
    sbq.push_back(exp);
    if (w) model_store(sz, a, wd);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    int c;
    model_fill();
    #3;
    checks += 5;
    if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_init_busy: got %b want 1", init_busy); end
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    if (rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp_error: got %b want 0", rsp_error); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_reset_n = 1'b1;
    c = 0;
    while (init_busy && c < 100) begin
      c++; @(posedge clk); #1;
    end
    checks += 2;
    if (c != DEPTH) begin errors++; $display("FAIL init_length: got %0d cycles want %0d", c, DEPTH); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL init_ready: got %b want 1", req_ready); end
    issue(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, {1'b0, FILL});
  endtask

  task automatic test_word_rw();
    issue(1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344, {1'b0, 32'h0});
    issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, {1'b0, 32'h11223344});
    issue(1'b0, 2'b00, 1'b0, 32'h0B, 32'h0, {1'b0, 32'h00000011});
    issue(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, {1'b0, 32'h00001122});
  endtask

  task automatic test_signed();
    issue(1'b1, 2'b00, 1'b0, 32'h09, 32'hABCDEF80, {1'b0, 32'h0});
    issue(1'b0, 2'b00, 1'b1, 32'h09, 32'h0, {1'b0, 32'hFFFFFF80});
    issue(1'b0, 2'b01, 1'b1, 32'h08, 32'h0, {1'b0, 32'hFFFF8044});
    issue(1'b0, 2'b00, 1'b0, 32'h09, 32'h0, {1'b0, 32'h00000080});
    issue(1'b0, 2'b10, 1'b1, 32'h08, 32'h0, {1'b0, 32'h11228044});
    issue(1'b1, 2'b01, 1'b0, 32'h0E, 32'h1234BEEF, {1'b0, 32'h0});
    issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, {1'b0, 32'hBEEF0000});
    issue(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, {1'b0, 32'h0000BEEF});
  endtask

  task automatic test_errors();
    issue(1'b1, 2'b10, 1'b0, 32'h0A, 32'hDEADBEEF, {1'b1, 32'h0});
    issue(1'b0, 2'b01, 1'b0, 32'h05, 32'h0, {1'b1, 32'h0});
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, {1'b1, 32'h0});
    issue(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, {1'b1, 32'h0});
    issue(1'b1, 2'b11, 1'b0, 32'h0C, 32'hCAFEF00D, {1'b1, 32'h0});
    issue(1'b1, 2'b10, 1'b0, 32'h40, 32'h55555555, {1'b1, 32'h0});
    issue(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, {1'b1, 32'h0});
    issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, {1'b0, 32'h11228044});
    issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, {1'b0, 32'hBEEF0000});
    issue(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, {1'b0, FILL});
  endtask

  task automatic test_back_to_back();
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic        sg;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        sz = 2'($urandom_range(0, 2));
        a  = 32'($urandom_range(0, DEPTH - 1) * 4);
        if (sz == 2'b00) a = a + 32'($urandom_range(0, 3));
        if (sz == 2'b01) a = a + 32'($urandom_range(0, 1) * 2);
        wd = $urandom;
        issue(1'b1, sz, 1'b0, a, wd, model_resp(1'b1, sz, 1'b0, a));
      end else begin
        sg = 1'($urandom_range(0, 1));
        issue(1'b0, sz, sg, a, 32'h0, model_resp(1'b0, sz, sg, a));
      end
    end
  endtask

  task automatic test_reset_mid();
    int c;
    // Reset in READY with a response in flight: outputs drop at once.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h08; req_wdata = 32'h0;
    @(posedge clk); #1;
    mem_reset_n = 1'b0;
    #1;
    checks += 3;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset_rsp_valid: got %b want 0", rsp_valid); end
    if (req_ready !== 1'b0) begin errors++; $display("FAIL midreset_req_ready: got %b want 0", req_ready); end
    if (init_busy !== 1'b1) begin errors++; $display("FAIL midreset_init_busy: got %b want 1", init_busy); end
    sbq.delete();
    model_fill();
    @(posedge clk); #1;
    mem_reset_n = 1'b1;
    // Request stays valid; reset again at fill cycle 5.
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_early: got %b want 0 cycle %0d", req_ready, i); end
      @(posedge clk); #1;
    end
    mem_reset_n = 1'b0;
    @(posedge clk); #1;
    mem_reset_n = 1'b1;
    c = 0;
    while (!req_ready && c < 100) begin
      c++; @(posedge clk); #1;
    end
    checks++;
    if (c != DEPTH) begin errors++; $display("FAIL refill_length: got %0d cycles want %0d", c, DEPTH); end
    sbq.push_back({1'b0, FILL});
    @(posedge clk); #1;
    req_valid = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, {1'b0, FILL});
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_signed();
    test_errors();
    test_back_to_back();
    repeat (3) begin @(posedge clk); #1; end
    test_reset_mid();
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lane_memory.md
# lane_memory

Parametrised successor to the fixed-size word memory. A byte-addressable, little-endian RAM with a single request/response port and byte, halfword and word accesses. Reads are registered so the array can map to block RAM. After reset, a built-in fill sequencer writes a fill word into every location before the port accepts requests. It sits on the CPU data/instruction bus as program RAM or MMIO backing store.

## Interface
- NUM_OF_BYTES, 1024: capacity in bytes; power of two, at least 8.
- FILL_WORD, 32'hE1A00000: value written to every word during init (MOV R0,R0 NOP).
- clk  in  1  sole clock; everything is sampled on the rising edge.
- mem_reset_n  in  1  reset; asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  loads only: sign-extend sub-word data.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (bits [7:0] for a byte).
- rsp_valid  out  1  one-cycle pulse that completes an accepted request.
- rsp_rdata  out  32  load data, right-aligned and extended; 0 for stores and for errors.
- rsp_error  out  1  the accepted request was out of range, misaligned or illegal-size.
- init_busy  out  1  the fill sequencer is running.

## Operation
- Storage: NUM_OF_BYTES/4 words (DEPTH) of 32 bits, with a 4-bit byte-enable per write. Byte k of word w sits at byte address 4w+k, little-endian.
- States: INIT and READY.
  - Reset puts the block in INIT with fill pointer 0.
  - In INIT, each cycle writes FILL_WORD to word[ptr] and increments ptr.
  - After the write to DEPTH-1, the block moves to READY.
- req_ready = (state == READY). Requests presented during INIT are ignored and must be held by the master.
- Error checks, evaluated in this order; any one sets rsp_error:
  - req_size == 11.
  - req_addr >= NUM_OF_BYTES, compared on the full 32 bits with no wrap.
  - Halfword with addr[0] = 1.
  - Word with addr[1:0] != 0.
- An errored store writes nothing. An errored load returns rsp_rdata = 0.
- Stores:
  - Byte: data is replicated to all lanes, byte-enable = 1 << addr[1:0].
  - Halfword: enable 0011 or 1100, selected by addr[1].
  - Word: enable 1111.
- Loads: select the lane or lanes by addr[1:0], right-align, then extend. Zero-extend by default; sign-extend from bit 7 or bit 15 when req_signed = 1. Word loads ignore req_signed.
- One request is accepted per cycle. The response carries no backpressure.

## Timing
- Reset values (asynchronous): state INIT, ptr 0, init_busy 1, req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_error 0.
- Init takes exactly DEPTH cycles. The first rising edge after reset release writes word 0. req_ready rises in cycle DEPTH, counting the first post-release cycle as cycle 0.
- Latency: a request accepted at edge N produces rsp_valid, rsp_rdata and rsp_error valid during the cycle after edge N, for exactly one cycle.
- Back-to-back accesses are fully pipelined at one per cycle.
- A store at edge N is visible to a load accepted at edge N+1 (read-after-write returns the new data).
- Responses to requests accepted at consecutive edges appear on consecutive cycles. rsp_valid is 0 in any cycle that follows an edge with no acceptance.
- Reset asserted mid-operation, in INIT or READY:
  - Immediately drops rsp_valid and req_ready.
  - Discards any in-flight response.
  - Restarts the fill from word 0 after release.
  - Array contents are not guaranteed until the fill completes.

## Structure
- Package lane_mem_pkg holds:
  - SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_ILLEGAL encodings.
  - The state enum (INIT, READY).
  - NOP_WORD = 32'hE1A00000.
- Sub-module lane_steer is purely combinational. Inputs: addr[1:0], size, signed, wdata and read word. Outputs: byte-enable, lane-replicated write word, and aligned/extended load data.
- The top level holds:
  - The array.
  - The fill counter of width $clog2(DEPTH)+1.
  - The response registers.
  - The error-check logic.

## Test plan
- Reset then release, NUM_OF_BYTES = 64:
  - init_busy is high for 16 cycles and req_ready rises in cycle 16.
  - A word load from 0x3C returns 0xE1A00000.
- Word store 0x11223344 to 0x08, then a load on the next cycle:
  - Word load returns 0x11223344 one cycle after acceptance.
  - Byte load from 0x0B returns 0x00000011.
  - Halfword load from 0x0A returns 0x00001122.
- Byte store 0x80 to 0x09, then signed byte load from 0x09 returns 0xFFFFFF80. Signed halfword load from 0x08 returns 0xFFFF8044.
- Error cases, each giving rsp_error = 1 and rsp_rdata = 0 with memory unchanged:
  - Word store to 0x0A.
  - Halfword load from 0x05.
  - Load from 0x40.
  - req_size 11.
- Ten consecutive alternating store/load requests at one per cycle produce ten consecutive rsp_valid pulses in order, each with correct data.
- Reset pulsed at fill cycle 5, with a request held valid throughout:
  - The request is not accepted during the fill.
  - The fill restarts and lasts a full DEPTH cycles.
  - The request is accepted in the first READY cycle.
